serial_add_sub: RTL and testbench

- Parametrised multi-cycle adder/subtractor; successor to the 1-bit full add/sub cell.
- Processes WIDTH-bit operands STEP bits per clock through a chained add/sub slice, carrying carry/borrow across cycles.
- Mode m selects add or subtract.
- Start/busy/done handshake. Reports result, carry/borrow out and signed overflow.
- Used wherever a wide add/sub is needed without a full-width parallel adder.

---
 rtl/serial_add_sub_if.sv | 30 +++
 rtl/serial_add_sub.sv | 142 ++++++++++++++
 tb/tb_serial_add_sub.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: handshake and data bundle for the serial adder/subtractor.
//   start, m, a, b, cin   request side (driven by the master)
//   busy, done            status (driven by the slave)
//   result, cout, ovf     completed-operation outputs (driven by the slave)
interface serial_add_sub_if #(
   parameter int unsigned WIDTH = 8
);

   logic             start;
   logic             m;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             ovf;

   modport master (
      output start, m, a, b, cin,
      input  busy, done, result, cout, ovf
   );

   modport slave (
      input  start, m, a, b, cin,
      output busy, done, result, cout, ovf
   );

endinterface

// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle WIDTH-bit adder/subtractor processing STEP bits per clock.
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   bus       serial_add_sub_if slave port:
//               start/m/a/b/cin in  - request, sampled when not busy
//               busy/done out       - in progress / one-cycle completion pulse
//               result/cout/ovf out - last completed sum/difference, carry/borrow, overflow
// The WIDTH parameter must match the WIDTH of the connected interface instance.
module serial_add_sub #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned STEP  = 1
) (
   input logic            clk,
   input logic            rst,
   serial_add_sub_if.slave bus
);

   localparam int unsigned N  = WIDTH / STEP;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e state_q, state_d;

   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] acc_q;
   logic             m_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] result_q;
   logic             cout_q;
   logic             ovf_q;

   logic             accept;
   logic             last_chunk;
   logic [STEP-1:0]  slice_sum;
   logic             carry_msb_in;
   logic             carry_out;
   logic             slice_a, slice_b, slice_c;
   logic [WIDTH+STEP-1:0] acc_wide;
   logic [WIDTH-1:0] acc_next;

   // A new request is taken in IDLE and also in DONE (back-to-back operation).
   assign accept     = bus.start && (state_q != StRun);
   assign last_chunk = (cnt_q == CW'(N - 1));

   // Chained add/sub slice over the low STEP bits of the shifted operands.
   always_comb begin : slice
      slice_sum    = '0;
      slice_c      = carry_q;
      carry_msb_in = carry_q;
      slice_a      = 1'b0;
      slice_b      = 1'b0;
      for (int i = 0; i < STEP; i++) begin
         slice_a      = a_q[i];
         slice_b      = b_q[i];
         slice_sum[i] = slice_a ^ slice_b ^ slice_c;
         // After the loop this holds the carry into the top bit of the slice,
         // which on the final chunk is the carry into the operand MSB.
         carry_msb_in = slice_c;
         if (m_q) begin
            slice_c = (~slice_a & slice_b) | (slice_c & ~(slice_a ^ slice_b));
         end else begin
            slice_c = (slice_a & slice_b) | (slice_c & (slice_a ^ slice_b));
         end
      end
      carry_out = slice_c;
   end

   // New sum bits enter from the MSB side; after N chunks acc holds the full value.
   assign acc_wide = {slice_sum, acc_q};
   assign acc_next = acc_wide[WIDTH+STEP-1:STEP];

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) state_d = StRun;
         end
         StRun: begin
            if (last_chunk) state_d = StDone;
         end
         StDone: begin
            state_d = bus.start ? StRun : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs.
   always_comb begin
      bus.busy   = (state_q == StRun);
      bus.done   = (state_q == StDone);
      bus.result = result_q;
      bus.cout   = cout_q;
      bus.ovf    = ovf_q;
   end

   // Datapath: operand shift registers, carry chain, counter and result hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         m_q      <= 1'b0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (accept) begin
         a_q     <= bus.a;
         b_q     <= bus.b;
         acc_q   <= '0;
         m_q     <= bus.m;
         carry_q <= bus.cin;
         cnt_q   <= '0;
      end else if (state_q == StRun) begin
         a_q     <= a_q >> STEP;
         b_q     <= b_q >> STEP;
         acc_q   <= acc_next;
         carry_q <= carry_out;
         cnt_q   <= cnt_q + 1'b1;
         if (last_chunk) begin
            result_q <= acc_next;
            cout_q   <= carry_out;
            ovf_q    <= carry_out ^ carry_msb_in;
         end
      end
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: self-checking bench for serial_add_sub.
// Instances: WIDTH=8/STEP=1 (directed table and sequences), WIDTH=4 with STEP=2 and
// STEP=4 (exhaustive against an arithmetic model). Expected results are queued when a
// request is driven and compared when done is seen.
module tb_serial_add_sub;

   logic clk;
   logic rst;

   serial_add_sub_if #(.WIDTH(8)) bus8 ();
   serial_add_sub_if #(.WIDTH(4)) bus2 ();
   serial_add_sub_if #(.WIDTH(4)) bus4 ();

   serial_add_sub #(.WIDTH(8), .STEP(1)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
   serial_add_sub #(.WIDTH(4), .STEP(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
   serial_add_sub #(.WIDTH(4), .STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       m;
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] res;
      logic       cout;
      logic       ovf;
   } vec_t;

   typedef struct packed {
      logic [7:0] res;
      logic       cout;
      logic       ovf;
   } exp8_t;

   exp8_t      q8[$];
   logic [5:0] q2[$];
   logic [5:0] q4[$];

   int passed = 0;
   int total  = 0;
   int done8_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   task automatic unexpected_done(input string name);
      total++;
      $display("FAIL %s: done pulse with no operation pending", name);
   endtask

   // {result[3:0], cout, ovf} from plain integer arithmetic.
   function automatic logic [5:0] model4(input logic m, input logic [3:0] a,
                                         input logic [3:0] b, input logic cin);
      int ua, ub, sa, sb, r, sr;
      logic co, ov;
      logic [31:0] rv;
      ua = a;
      ub = b;
      sa = a[3] ? ua - 16 : ua;
      sb = b[3] ? ub - 16 : ub;
      if (!m) begin
         r  = ua + ub + int'(cin);
         co = (r >= 16);
         sr = sa + sb + int'(cin);
      end else begin
         r  = ua - ub - int'(cin);
         co = (ua < ub + int'(cin));
         sr = sa - sb - int'(cin);
      end
      ov = (sr > 7) || (sr < -8);
      rv = r;
      return {rv[3:0], co, ov};
   endfunction

   // Scoreboard monitors.
   always @(negedge clk) begin
      if (bus8.done) begin
         done8_cnt++;
         if (q8.size() == 0) begin
            unexpected_done("dut8");
         end else begin
            exp8_t e;
            e = q8.pop_front();
            check("dut8 result", bus8.result, e.res);
            check("dut8 cout", bus8.cout, e.cout);
            check("dut8 ovf", bus8.ovf, e.ovf);
         end
      end
   end

   always @(negedge clk) begin
      if (bus2.done) begin
         if (q2.size() == 0) begin
            unexpected_done("dut2");
         end else begin
            logic [5:0] e;
            e = q2.pop_front();
            check("dut2 result/cout/ovf", {bus2.result, bus2.cout, bus2.ovf}, e);
         end
      end
   end

   always @(negedge clk) begin
      if (bus4.done) begin
         if (q4.size() == 0) begin
            unexpected_done("dut4");
         end else begin
            logic [5:0] e;
            e = q4.pop_front();
            check("dut4 result/cout/ovf", {bus4.result, bus4.cout, bus4.ovf}, e);
         end
      end
   end

   // Wait (from #1 after the accept edge) for dut8 done; returns edges counted.
   task automatic wait_done8(output int edges, output logic busy_ok);
      edges   = 0;
      busy_ok = 1'b1;
      while (!bus8.done && edges < 20) begin
         if (!bus8.busy) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   task automatic run8(input vec_t v, input string tag);
      int   edges;
      logic busy_ok;
      @(negedge clk);
      bus8.start = 1'b1;
      bus8.m     = v.m;
      bus8.a     = v.a;
      bus8.b     = v.b;
      bus8.cin   = v.cin;
      q8.push_back('{res: v.res, cout: v.cout, ovf: v.ovf});
      @(posedge clk);
      #1;
      bus8.start = 1'b0;
      wait_done8(edges, busy_ok);
      check({tag, " latency"}, edges, 8);
      check({tag, " busy during run"}, busy_ok, 1'b1);
      check({tag, " busy low at done"}, bus8.busy, 1'b0);
      @(posedge clk);
      #1;
      check({tag, " done one cycle"}, bus8.done, 1'b0);
   endtask

   vec_t vecs[7];

   initial begin
      int   edges;
      logic busy_ok;
      int   snap;

      vecs[0] = '{m: 1'b0, a: 8'h7F, b: 8'h01, cin: 1'b0, res: 8'h80, cout: 1'b0, ovf: 1'b1};
      vecs[1] = '{m: 1'b0, a: 8'hFF, b: 8'h01, cin: 1'b0, res: 8'h00, cout: 1'b1, ovf: 1'b0};
      vecs[2] = '{m: 1'b1, a: 8'h05, b: 8'h07, cin: 1'b0, res: 8'hFE, cout: 1'b1, ovf: 1'b0};
      vecs[3] = '{m: 1'b1, a: 8'h80, b: 8'h01, cin: 1'b0, res: 8'h7F, cout: 1'b0, ovf: 1'b1};
      vecs[4] = '{m: 1'b1, a: 8'h10, b: 8'h0F, cin: 1'b1, res: 8'h00, cout: 1'b0, ovf: 1'b0};
      vecs[5] = '{m: 1'b0, a: 8'h80, b: 8'h80, cin: 1'b1, res: 8'h01, cout: 1'b1, ovf: 1'b1};
      vecs[6] = '{m: 1'b1, a: 8'h00, b: 8'h00, cin: 1'b1, res: 8'hFF, cout: 1'b1, ovf: 1'b0};

      {bus8.start, bus8.m, bus8.a, bus8.b, bus8.cin} = '0;
      {bus2.start, bus2.m, bus2.a, bus2.b, bus2.cin} = '0;
      {bus4.start, bus4.m, bus4.a, bus4.b, bus4.cin} = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset dut8 outputs",
            {bus8.busy, bus8.done, bus8.result, bus8.cout, bus8.ovf}, 32'd0);
      check("reset dut2 outputs",
            {bus2.busy, bus2.done, bus2.result, bus2.cout, bus2.ovf}, 32'd0);

      // Directed table.
      for (int i = 0; i < 7; i++) begin
         run8(vecs[i], $sformatf("vec%0d", i));
      end

      // Start held high with operands churning during RUN, then back-to-back accept.
      @(negedge clk);
      bus8.start = 1'b1;
      bus8.m     = 1'b0;
      bus8.a     = 8'h12;
      bus8.b     = 8'h34;
      bus8.cin   = 1'b0;
      q8.push_back('{res: 8'h46, cout: 1'b0, ovf: 1'b0});
      @(posedge clk);
      #1;
      edges = 0;
      while (!bus8.done && edges < 20) begin
         bus8.a   = 8'($urandom);
         bus8.b   = 8'($urandom);
         bus8.m   = 1'($urandom);
         bus8.cin = 1'($urandom);
         @(posedge clk);
         #1;
         edges++;
      end
      check("held start latency", edges, 8);
      bus8.m   = 1'b1;
      bus8.a   = 8'h60;
      bus8.b   = 8'h0F;
      bus8.cin = 1'b0;
      q8.push_back('{res: 8'h51, cout: 1'b0, ovf: 1'b0});
      @(posedge clk);
      #1;
      bus8.start = 1'b0;
      check("b2b done drops", bus8.done, 1'b0);
      check("b2b busy rises", bus8.busy, 1'b1);
      wait_done8(edges, busy_ok);
      check("b2b latency", edges, 8);
      check("b2b busy during run", busy_ok, 1'b1);
      @(posedge clk);
      #1;

      // Reset in the 4th RUN cycle discards the operation.
      bus8.start = 1'b1;
      bus8.m     = 1'b0;
      bus8.a     = 8'h7F;
      bus8.b     = 8'h01;
      bus8.cin   = 1'b0;
      @(posedge clk);
      #1;
      bus8.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrun reset outputs",
            {bus8.busy, bus8.done, bus8.result, bus8.cout, bus8.ovf}, 32'd0);
      snap = done8_cnt;
      repeat (15) @(posedge clk);
      #1;
      check("no done after reset", done8_cnt, snap);

      // Exhaustive WIDTH=4: both 4-bit instances get identical requests.
      for (int mi = 0; mi < 2; mi++) begin
         for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
               for (int ci = 0; ci < 2; ci++) begin
                  logic s2, s4;
                  bus2.m   = 1'(mi);
                  bus2.a   = 4'(ai);
                  bus2.b   = 4'(bi);
                  bus2.cin = 1'(ci);
                  bus4.m   = 1'(mi);
                  bus4.a   = 4'(ai);
                  bus4.b   = 4'(bi);
                  bus4.cin = 1'(ci);
                  bus2.start = 1'b1;
                  bus4.start = 1'b1;
                  q2.push_back(model4(1'(mi), 4'(ai), 4'(bi), 1'(ci)));
                  q4.push_back(model4(1'(mi), 4'(ai), 4'(bi), 1'(ci)));
                  @(posedge clk);
                  #1;
                  bus2.start = 1'b0;
                  bus4.start = 1'b0;
                  edges = 0;
                  s2 = 1'b0;
                  s4 = 1'b0;
                  while (!(s2 && s4) && edges < 10) begin
                     @(posedge clk);
                     #1;
                     edges++;
                     if (bus4.done && !s4) begin
                        s4 = 1'b1;
                        check("dut4 latency", edges, 1);
                     end
                     if (bus2.done && !s2) begin
                        s2 = 1'b1;
                        check("dut2 latency", edges, 2);
                     end
                  end
                  if (!(s2 && s4)) check("4-bit done timeout", {s2, s4}, 2'b11);
               end
            end
         end
      end

      repeat (3) @(posedge clk);
      #1;
      check("dut8 queue drained", q8.size(), 0);
      check("dut2 queue drained", q2.size(), 0);
      check("dut4 queue drained", q4.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
